// File: rtl/wide_inv_pkg.sv
// -----------------------------------------------------------------------------
// wide_inv_pkg
// Shared definitions for the wide inverting-register pattern checker: the data
// width, the pattern table, the checker state encoding, and index constants.
// -----------------------------------------------------------------------------
package wide_inv_pkg;

  localparam int WIDTH   = 32;
  localparam int NUM_PAT = 11;

  typedef logic [WIDTH-1:0] word_t;
  typedef logic [3:0]       idx_t;

  // Marks "no mismatch seen yet" in first_err_idx.
  localparam idx_t IDX_NONE = 4'hF;
  localparam idx_t LAST_IDX = idx_t'(NUM_PAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Stimulus words in issue order. The device under check must return the
  // bitwise inverse of each one.
  localparam word_t PAT [NUM_PAT] = '{
    32'h0000_0000,
    32'hFFFF_FFFF,
    32'hFFFF_0000,
    32'h0000_FFFF,
    32'h5555_5555,
    32'hAAAA_AAAA,
    32'h1111_1111,
    32'h2222_2222,
    32'h4444_4444,
    32'h8888_8888,
    32'h0000_0000
  };

endpackage

// File: rtl/wide_inv_pat_chk_if.sv
// -----------------------------------------------------------------------------
// wide_inv_pat_chk_if
// Bundles the checker's control, stimulus and result signals.
//   master : the checker (drives d_in and the status/result outputs)
//   slave  : the environment (drives start and the device response d_out)
// Signals:
//   start         - begin one pattern run (honoured only while idle)
//   d_in          - stimulus word to the device under check
//   d_out         - device response, expected ~d_in after LATENCY cycles
//   busy          - run or drain in progress
//   done          - one-cycle pulse when the last comparison has completed
//   pass          - result of the last completed run (1 = no mismatches)
//   err_count     - mismatching vectors, saturating at 255
//   first_err_idx - index of the first mismatching vector, 4'hF if none
// -----------------------------------------------------------------------------
interface wide_inv_pat_chk_if;
  import wide_inv_pkg::*;

  logic       start;
  word_t      d_in;
  word_t      d_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  idx_t       first_err_idx;

  modport master (
    input  start, d_out,
    output d_in, busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    output start, d_out,
    input  d_in, busy, done, pass, err_count, first_err_idx
  );

endinterface

// File: rtl/wide_inv_pat_rom.sv
// -----------------------------------------------------------------------------
// wide_inv_pat_rom
// Combinational pattern table lookup.
//   idx  : 4-bit vector index
//   word : pattern word; indices past the end of the table return zero
// -----------------------------------------------------------------------------
module wide_inv_pat_rom
  import wide_inv_pkg::*;
(
  input  idx_t  idx,
  output word_t word
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    word = '0;
    if (idx <= LAST_IDX) begin
      word = PAT[idx];
    end
  end

endmodule

// File: rtl/wide_inv_pat_chk.sv
// -----------------------------------------------------------------------------
// wide_inv_pat_chk
// Drives a fixed table of 11 words into an inverting register pipeline and
// checks that each response equals the inverse of its stimulus LATENCY cycles
// later. Reports a mismatch count, the first failing index and a pass flag.
//   clock : single clock, rising edge
//   rst   : synchronous, active-low reset
//   bus   : checker side of wide_inv_pat_chk_if (see interface header)
// Parameter LATENCY (1..4): register stages in the device under check.
// -----------------------------------------------------------------------------
module wide_inv_pat_chk
  import wide_inv_pkg::*;
#(
  parameter int LATENCY = 1
)(
  input  logic               clock,
  input  logic               rst,
  wide_inv_pat_chk_if.master bus
);

  localparam logic [1:0] DRAIN_LAST = 2'(LATENCY - 1);

  state_t     state_q, state_nxt;
  word_t      d_in_q;
  idx_t       idx_q;        // index of the vector currently on d_in
  logic [1:0] drain_cnt_q;
  logic       drain_last;

  idx_t       rom_addr;
  word_t      rom_word;

  // Delay line: expected response, vector index and valid flag per stage.
  logic [LATENCY-1:0] vld_q;
  word_t              exp_q  [LATENCY];
  idx_t               eidx_q [LATENCY];

  logic       cmp_valid;
  logic       mismatch;
  logic [7:0] err_q, err_nxt;
  idx_t       first_q, first_nxt;
  logic       pass_q;
  logic       launch;

  assign drain_last = (drain_cnt_q == DRAIN_LAST);
  assign launch     = (state_q == ST_IDLE) && bus.start;

  // In IDLE the next word to register is vector 0; in RUN it is the successor
  // of the one on d_in.
  assign rom_addr = (state_q == ST_IDLE) ? '0 : idx_q + 4'd1;

  wide_inv_pat_rom u_rom (
    .idx  (rom_addr),
    .word (rom_word)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clock) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start)          state_nxt = ST_RUN;
      ST_RUN:   if (idx_q == LAST_IDX)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_last)         state_nxt = ST_DONE;
      ST_DONE:                          state_nxt = ST_IDLE;
      default:                          state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs decoded from state
  always_comb begin
    bus.busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    bus.done = (state_q == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // Stimulus register, vector index and drain counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!rst) begin
      d_in_q      <= '0;
      idx_q       <= '0;
      drain_cnt_q <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            d_in_q <= rom_word;
            idx_q  <= '0;
          end
        end
        ST_RUN: begin
          if (idx_q == LAST_IDX) begin
            d_in_q      <= '0;
            drain_cnt_q <= '0;
          end else begin
            d_in_q <= rom_word;
            idx_q  <= idx_q + 4'd1;
          end
        end
        ST_DRAIN: drain_cnt_q <= drain_cnt_q + 2'd1;
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Expected-value delay line. Stage 0 captures the vector driven during the
  // cycle just ending; the last stage lines up with d_out LATENCY cycles on.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= (state_q == ST_RUN);
      for (int i = 1; i < LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
    end
  end

  // NOTE: the data stages are deliberately left out of reset; they are only
  // ever consumed behind the valid bits, which are reset.
  always_ff @(posedge clock) begin
    exp_q[0]  <= ~d_in_q;
    eidx_q[0] <= idx_q;
    for (int i = 1; i < LATENCY; i++) begin
      exp_q[i]  <= exp_q[i-1];
      eidx_q[i] <= eidx_q[i-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Comparison and result accumulation
  // ---------------------------------------------------------------------------
  assign cmp_valid = vld_q[LATENCY-1];
  assign mismatch  = (bus.d_out != exp_q[LATENCY-1]);

  always_comb begin
    err_nxt   = err_q;
    first_nxt = first_q;
    if (cmp_valid && mismatch) begin
      if (err_q != 8'hFF) begin
        err_nxt = err_q + 8'd1;
      end
      if (first_q == IDX_NONE) begin
        first_nxt = eidx_q[LATENCY-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!rst) begin
      err_q   <= '0;
      first_q <= IDX_NONE;
      pass_q  <= 1'b0;
    end else if (launch) begin
      err_q   <= '0;
      first_q <= IDX_NONE;
      pass_q  <= 1'b0;
    end else begin
      err_q   <= err_nxt;
      first_q <= first_nxt;
      // The final comparison lands on the same edge that enters DONE, so the
      // verdict is taken from the post-comparison count.
      if ((state_q == ST_DRAIN) && drain_last) begin
        pass_q <= (err_nxt == 8'd0);
      end
    end
  end

  assign bus.d_in          = d_in_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_q;
  assign bus.first_err_idx = first_q;

endmodule

// File: tb/tb_wide_inv_pat_chk.sv
// -----------------------------------------------------------------------------
// tb_wide_inv_pat_chk
// Two checker instances (LATENCY 1 and 3), each facing a behavioural register
// model whose depth and fault mode are selectable. Stimulus words and run
// results are predicted by the bench and queued; they are popped and compared
// as the checker emits them.
// -----------------------------------------------------------------------------
module tb_wide_inv_pat_chk;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] TB_PAT [0:10] = '{
    32'h00000000, 32'hFFFFFFFF, 32'hFFFF0000, 32'h0000FFFF,
    32'h55555555, 32'hAAAAAAAA, 32'h11111111, 32'h22222222,
    32'h44444444, 32'h88888888, 32'h00000000
  };

  typedef struct {
    logic [7:0] ec;
    logic [3:0] fi;
    logic       ps;
  } res_t;

  logic [31:0] dq [$];
  res_t        rq [$];

  // Model: 0 = inverting, 1 = inverting with bit 0 stuck at 0, 2 = non-inverting
  int         model_mode = 0;
  logic [1:0] model_tap  = 2'd0;   // depth - 1
  bit         sel3       = 1'b0;   // observe/drive the LATENCY=3 instance

  wide_inv_pat_chk_if bus1 ();
  wide_inv_pat_chk_if bus3 ();

  wide_inv_pat_chk #(.LATENCY(1)) dut1 (.clock(clock), .rst(rst), .bus(bus1));
  wide_inv_pat_chk #(.LATENCY(3)) dut3 (.clock(clock), .rst(rst), .bus(bus3));

  function automatic logic [31:0] xform(input int mode, input logic [31:0] x);
    case (mode)
      0:       return ~x;
      1:       return ~x & 32'hFFFF_FFFE;
      default: return x;
    endcase
  endfunction

  logic [31:0] m1 [4];
  logic [31:0] m3 [4];
  always @(posedge clock) begin
    m1[0] <= bus1.d_in; m1[1] <= m1[0]; m1[2] <= m1[1]; m1[3] <= m1[2];
    m3[0] <= bus3.d_in; m3[1] <= m3[0]; m3[2] <= m3[1]; m3[3] <= m3[2];
  end
  assign bus1.d_out = xform(model_mode, m1[model_tap]);
  assign bus3.d_out = xform(model_mode, m3[model_tap]);

  logic [31:0] o_d_in;
  logic        o_busy, o_done, o_pass;
  logic [7:0]  o_err;
  logic [3:0]  o_first;
  assign o_d_in  = sel3 ? bus3.d_in          : bus1.d_in;
  assign o_busy  = sel3 ? bus3.busy          : bus1.busy;
  assign o_done  = sel3 ? bus3.done          : bus1.done;
  assign o_pass  = sel3 ? bus3.pass          : bus1.pass;
  assign o_err   = sel3 ? bus3.err_count     : bus1.err_count;
  assign o_first = sel3 ? bus3.first_err_idx : bus1.first_err_idx;

  task automatic set_start(input bit v);
    if (sel3) bus3.start = v;
    else      bus1.start = v;
  endtask

  // One full run on the selected instance with the current model settings.
  // pulse_mid additionally pulses start during RUN, DRAIN and DONE.
  task automatic do_run(input string name, input int lat, input bit pulse_mid);
    res_t        exp_r;
    res_t        got_r;
    logic [31:0] w;
    logic [31:0] src;
    int          j;
    repeat (5) @(negedge clock);
    exp_r.ec = 8'd0;
    exp_r.fi = 4'hF;
    for (int k = 0; k < 11; k++) begin
      dq.push_back(TB_PAT[k]);
      // Response seen when vector k is checked: model output for the word on
      // d_in (lat - depth) cycles around the vector's own issue cycle k+1.
      j   = k + 1 + lat - (int'(model_tap) + 1);
      src = 32'h0;
      if (j >= 1 && j <= 11) src = TB_PAT[j-1];
      if (xform(model_mode, src) !== ~TB_PAT[k]) begin
        exp_r.ec = exp_r.ec + 8'd1;
        if (exp_r.fi == 4'hF) exp_r.fi = 4'(k);
      end
    end
    exp_r.ps = (exp_r.ec == 8'd0);
    rq.push_back(exp_r);
    got_r = exp_r;
    set_start(1'b1);
    for (int n = 1; n <= 15 + lat; n++) begin
      @(negedge clock);
      if (n <= 11) begin
        w = dq.pop_front();
        checks++;
        if (o_d_in !== w || o_busy !== 1'b1 || o_done !== 1'b0) begin
          failures++;
          $display("FAIL %s run_vec cyc=%0d d_in=%h busy=%b done=%b exp d_in=%h busy=1 done=0",
                   name, n, o_d_in, o_busy, o_done, w);
        end
      end else if (n <= 11 + lat) begin
        checks++;
        if (o_d_in !== 32'h0 || o_busy !== 1'b1 || o_done !== 1'b0) begin
          failures++;
          $display("FAIL %s drain cyc=%0d d_in=%h busy=%b done=%b exp 0/1/0",
                   name, n, o_d_in, o_busy, o_done);
        end
      end else if (n == 12 + lat) begin
        got_r = rq.pop_front();
        checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
          failures++;
          $display("FAIL %s done_pulse cyc=%0d done=%b busy=%b exp 1/0", name, n, o_done, o_busy);
        end
        checks++;
        if (o_err !== got_r.ec || o_first !== got_r.fi || o_pass !== got_r.ps) begin
          failures++;
          $display("FAIL %s result err=%0d first=%h pass=%b exp err=%0d first=%h pass=%b",
                   name, o_err, o_first, o_pass, got_r.ec, got_r.fi, got_r.ps);
        end
      end else begin
        checks++;
        if (o_done !== 1'b0 || o_busy !== 1'b0 || o_pass !== got_r.ps) begin
          failures++;
          $display("FAIL %s post_idle cyc=%0d done=%b busy=%b pass=%b exp 0/0/%b",
                   name, n, o_done, o_busy, o_pass, got_r.ps);
        end
      end
      set_start(pulse_mid && (n == 4 || n == 12 || n == 12 + lat));
    end
    set_start(1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clock);
    checks++;
    if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.pass !== 1'b0 ||
        bus1.d_in !== 32'h0 || bus1.err_count !== 8'h0 || bus1.first_err_idx !== 4'hF) begin
      failures++;
      $display("FAIL reset_l1 busy=%b done=%b pass=%b d_in=%h err=%0d first=%h",
               bus1.busy, bus1.done, bus1.pass, bus1.d_in, bus1.err_count, bus1.first_err_idx);
    end
    checks++;
    if (bus3.busy !== 1'b0 || bus3.done !== 1'b0 || bus3.pass !== 1'b0 ||
        bus3.d_in !== 32'h0 || bus3.err_count !== 8'h0 || bus3.first_err_idx !== 4'hF) begin
      failures++;
      $display("FAIL reset_l3 busy=%b done=%b pass=%b d_in=%h err=%0d first=%h",
               bus3.busy, bus3.done, bus3.pass, bus3.d_in, bus3.err_count, bus3.first_err_idx);
    end
    rst = 1'b1;
  endtask

  task automatic test_clean();
    sel3 = 1'b0; model_mode = 0; model_tap = 2'd0;
    do_run("clean_l1", 1, 1'b0);
  endtask

  task automatic test_stuck_bit();
    sel3 = 1'b0; model_mode = 1; model_tap = 2'd0;
    do_run("stuck0_l1", 1, 1'b0);
    checks++;
    if (bus1.err_count !== 8'd7 || bus1.first_err_idx !== 4'h0 || bus1.pass !== 1'b0) begin
      failures++;
      $display("FAIL stuck0_abs err=%0d first=%h pass=%b exp 7/0/0",
               bus1.err_count, bus1.first_err_idx, bus1.pass);
    end
  endtask

  task automatic test_non_inverting();
    sel3 = 1'b0; model_mode = 2; model_tap = 2'd0;
    do_run("noninv_l1", 1, 1'b0);
    checks++;
    if (bus1.err_count !== 8'd11 || bus1.first_err_idx !== 4'h0 || bus1.pass !== 1'b0) begin
      failures++;
      $display("FAIL noninv_abs err=%0d first=%h pass=%b exp 11/0/0",
               bus1.err_count, bus1.first_err_idx, bus1.pass);
    end
    model_mode = 0;
  endtask

  task automatic test_latency();
    model_mode = 0; model_tap = 2'd2;
    sel3 = 1'b1;
    do_run("lat3_model3", 3, 1'b0);
    sel3 = 1'b0;
    do_run("lat1_model3", 1, 1'b0);
    checks++;
    if (bus1.pass !== 1'b0) begin
      failures++;
      $display("FAIL lat1_model3_pass pass=%b exp 0", bus1.pass);
    end
    model_tap = 2'd0;
    repeat (5) @(negedge clock);
  endtask

  task automatic test_start_ignored();
    sel3 = 1'b0; model_mode = 1; model_tap = 2'd0;
    do_run("midstart_l1", 1, 1'b1);
    model_mode = 0;
  endtask

  task automatic test_back_to_back();
    int n  = 0;
    int d1 = 0;
    int d2 = 0;
    sel3 = 1'b0; model_mode = 0; model_tap = 2'd0;
    repeat (5) @(negedge clock);
    bus1.start = 1'b1;
    while (d2 == 0 && n < 80) begin
      @(negedge clock);
      n++;
      if (bus1.done === 1'b1) begin
        checks++;
        if (bus1.pass !== 1'b1 || bus1.err_count !== 8'd0) begin
          failures++;
          $display("FAIL b2b_result cyc=%0d pass=%b err=%0d exp 1/0", n, bus1.pass, bus1.err_count);
        end
        if (d1 == 0) d1 = n;
        else begin
          d2 = n;
          bus1.start = 1'b0;
        end
      end
    end
    bus1.start = 1'b0;
    checks++;
    if (d1 != 13 || d2 != 27) begin
      failures++;
      $display("FAIL b2b_timing done1=%0d done2=%0d exp 13/27", d1, d2);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (bus1.busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stop busy=%b exp 0", bus1.busy);
    end
  endtask

  task automatic test_abort();
    int dones = 0;
    sel3 = 1'b0; model_mode = 1; model_tap = 2'd0;
    repeat (5) @(negedge clock);
    // Idle reset must also drop a held pass flag.
    checks++;
    if (bus1.pass !== 1'b1) begin
      failures++;
      $display("FAIL abort_pre_pass pass=%b exp 1", bus1.pass);
    end
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    checks++;
    if (bus1.pass !== 1'b0) begin
      failures++;
      $display("FAIL reset_clears_pass pass=%b exp 0", bus1.pass);
    end
    repeat (3) @(negedge clock);
    bus1.start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      bus1.start = 1'b0;
    end
    // Cycle 6: vector 5 on d_in, vectors 0..3 already checked (fails at 0, 2).
    checks++;
    if (bus1.d_in !== TB_PAT[5] || bus1.err_count !== 8'd2) begin
      failures++;
      $display("FAIL abort_pre d_in=%h err=%0d exp %h/2", bus1.d_in, bus1.err_count, TB_PAT[5]);
    end
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
    checks++;
    if (bus1.busy !== 1'b0 || bus1.d_in !== 32'h0 || bus1.err_count !== 8'd0 ||
        bus1.first_err_idx !== 4'hF || bus1.done !== 1'b0) begin
      failures++;
      $display("FAIL abort_post busy=%b d_in=%h err=%0d first=%h done=%b exp 0/0/0/f/0",
               bus1.busy, bus1.d_in, bus1.err_count, bus1.first_err_idx, bus1.done);
    end
    repeat (20) begin
      @(negedge clock);
      if (bus1.done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      failures++;
      $display("FAIL abort_no_done pulses=%0d exp 0", dones);
    end
    model_mode = 0;
    do_run("after_abort_l1", 1, 1'b0);
  endtask

  initial begin
    bus1.start = 1'b0;
    bus3.start = 1'b0;
    test_reset();
    test_clean();
    test_stuck_bit();
    test_non_inverting();
    test_latency();
    test_start_ignored();
    test_back_to_back();
    test_abort();
    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wide_inv_pat_chk.md
WIDE_INV_PAT_CHK -- requirements
Module: wide_inv_pat_chk

Interface
REQ-001 Parameter LATENCY, default 1: number of register stages between d_in and d_out in the device under check; legal range 1..4.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  begin one pattern run; sampled only in IDLE.
REQ-005 d_in  output  32  stimulus word driven to the device's data input.
REQ-006 d_out  input  32  device response, expected to equal ~d_in delayed LATENCY cycles.
REQ-007 busy  output  1  high in RUN and DRAIN.
REQ-008 done  output  1  one-cycle pulse when the last comparison completes.
REQ-009 pass  output  1  result of the last completed run (1 = zero mismatches).
REQ-010 err_count  output  8  mismatching vectors in the current or last run, saturating at 255.
REQ-011 first_err_idx  output  4  index of the first mismatching vector; 4'hF if none.

Function
REQ-012 Pattern table, 11 entries in index order 0..10: 00000000, FFFFFFFF, FFFF0000, 0000FFFF, 55555555, AAAAAAAA, 11111111, 22222222, 44444444, 88888888, 00000000.
REQ-013 States: IDLE, RUN, DRAIN, DONE; encoding free.
REQ-014 IDLE: d_in = 0, busy = 0; start = 1 -> RUN, clear err_count to 0, first_err_idx to F, pass to 0.
REQ-015 RUN: d_in registered, one new vector per cycle, vector k in the k-th RUN cycle; after vector 10 -> DRAIN.
REQ-016 DRAIN: d_in = 0, lasts exactly LATENCY cycles, then -> DONE.
REQ-017 DONE: exactly one cycle; done = 1; pass = (err_count == 0), held until next start; -> IDLE.
REQ-018 Checking: vector k (on d_in during cycle c) is compared against d_out sampled at the end of cycle c+LATENCY; bitwise exact match to ~P[k] required.
REQ-019 Expected values and a valid flag travel a LATENCY-deep shift register; comparisons occur only when the delayed valid bit is set; d_out is ignored otherwise.
REQ-020 Mismatch: err_count increments (saturating); first_err_idx takes k only if still F.
REQ-021 Total run: start seen at edge E -> done high in cycle E+11+LATENCY+1 (counting cycles after E).
REQ-022 start while busy or in DONE is ignored; no restart, no counter clear.
REQ-023 start held high continuously: a new run begins on the cycle after DONE.

Reset
REQ-024 rst = 0 at a rising edge forces IDLE, d_in = 0, busy = 0, done = 0, pass = 0, err_count = 0, first_err_idx = F, shift register valid bits cleared.
REQ-025 Reset mid-run aborts the run without asserting done; no partial result is retained.

Structure
REQ-026 Shared package wide_inv_pkg holds: WIDTH = 32, NUM_PAT = 11, IDX_NONE = 4'hF, state encoding, pattern constants.
REQ-027 Pattern table is a combinational sub-module wide_inv_pat_rom (4-bit index in, 32-bit word out); indices 11..15 return 0.
REQ-028 FSM, delay line and counters live in wide_inv_pat_chk; no other sub-modules.

Verification
REQ-029 Correct inverting register model (LATENCY 1), start pulse -> all 11 vectors appear in order, done at cycle 13 after start, pass = 1, err_count = 0, first_err_idx = F.
REQ-030 Model with d_out[0] stuck at 0 -> err_count = 7 (indices 0,2,5,7,8,9,10), first_err_idx = 0, pass = 0.
REQ-031 Non-inverting model (d_out = delayed d_in) -> err_count = 11, first_err_idx = 0, pass = 0.
REQ-032 LATENCY = 3 with a 3-stage inverting model -> pass = 1, done at cycle 15; same model with LATENCY = 1 -> pass = 0.
REQ-033 rst = 0 asserted during RUN vector 5 -> next cycle IDLE, d_in = 0, err_count = 0, no done pulse; later start yields a full clean run.
REQ-034 start pulsed during RUN and DRAIN -> ignored, single done pulse, counts unaffected.
